seq_detect_non_ov: RTL and testbench

// - Moore-type serial bit-pattern detector with non-overlapping matches.
// - Samples one serial bit per clock on inbits.
// - Raises detect for exactly one cycle after a complete PATTERN is received.
// - After a match, restarts a fresh search; bits of the matched pattern are never reused.
// - Sits at the end of a serial bit stream as a framing/marker detector.

---
 rtl/seq_detect_non_ov_pkg.sv | 24 ++
 rtl/seq_detect_non_ov_if.sv | 9 +
 rtl/seq_detect_non_ov.sv | 31 +++
 tb/tb_seq_detect_non_ov.sv | 84 ++++++++
 4 files changed

// File: rtl/seq_detect_non_ov_pkg.sv
// seq_detect_pkg: state type, state constants and KMP next-state function shared by the detector
package seq_detect_pkg;
  localparam int MAX_LEN = 16;
  localparam int S0 = 0;
  typedef logic [$clog2(MAX_LEN+1)-1:0] state_t;
  // Next state after seeing bit b with k pattern bits already matched:
  // the longest suffix of (matched prefix + b) that is also a pattern prefix.
  // A full-length result equals len, i.e. the MATCH state.
  function automatic state_t fallback(logic [MAX_LEN-1:0] pat, int len, int k, logic b);
    logic ok;
    logic s;
    int p;
    for (int j = k + 1; j > 0; j--) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        p = k + 1 - j + i;
        s = (p == k) ? b : pat[4'(len - 1 - p)];
        if (s != pat[4'(len - 1 - i)]) ok = 1'b0;
      end
      if (ok) return state_t'(j);
    end
    return state_t'(S0);
  endfunction
endpackage

// File: rtl/seq_detect_non_ov_if.sv
// seq_detect_non_ov_if: serial bit stream in, detect pulse out
//   inbits : serial data bit, one per clock (master drives)
//   detect : one-cycle match pulse (slave drives)
interface seq_detect_non_ov_if;
  logic inbits;
  logic detect;
  modport master(output inbits, input detect);
  modport slave(input inbits, output detect);
endinterface

// File: rtl/seq_detect_non_ov.sv
// seq_detect_non_ov: Moore serial pattern detector with non-overlapping matches
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, returns to S0
//   bus   : slave side of seq_detect_non_ov_if (inbits in, detect out)
module seq_detect_non_ov
  import seq_detect_pkg::*;
#(
  parameter int PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011
) (
  input logic clk,
  input logic reset,
  seq_detect_non_ov_if.slave bus
);
  localparam int SW = $clog2(PAT_LEN + 1);
  localparam logic [SW-1:0] MATCH = SW'(PAT_LEN);
  logic [SW-1:0] r_state = SW'(S0);
  logic [SW-1:0] w_state_nxt;
  logic [SW-1:0] w_nxt [2**SW][2];
  // MATCH and unreachable encodings behave as S0, which gives the non-overlap restart
  for (genvar k = 0; k < 2**SW; k++) begin : g_tbl
    localparam int KK = (k >= PAT_LEN) ? S0 : k;
    assign w_nxt[k][0] = SW'(fallback(MAX_LEN'(PATTERN), PAT_LEN, KK, 1'b0));
    assign w_nxt[k][1] = SW'(fallback(MAX_LEN'(PATTERN), PAT_LEN, KK, 1'b1));
  end
  always_comb begin
    w_state_nxt = w_nxt[r_state][bus.inbits];
    bus.detect = (r_state == MATCH);
  end
  always_ff @(posedge clk) r_state <= reset ? SW'(S0) : w_state_nxt;
endmodule

// File: tb/tb_seq_detect_non_ov.sv
// tb_seq_detect_non_ov: directed vector check of the 1011 detector and a PAT_LEN=1 instance
module tb_seq_detect_non_ov;
  typedef struct packed {
    logic r;
    logic b;
    logic e;
  } vec_t;
  logic clk = 1'b0;
  logic reset_a = 1'b0;
  logic reset_b = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs[$];
  seq_detect_non_ov_if if_a();
  seq_detect_non_ov_if if_b();
  seq_detect_non_ov #(.PAT_LEN(4), .PATTERN(4'b1011)) dut_a (.clk(clk), .reset(reset_a), .bus(if_a.slave));
  seq_detect_non_ov #(.PAT_LEN(1), .PATTERN(1'b1)) dut_b (.clk(clk), .reset(reset_b), .bus(if_b.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: detect=%b expected %b", name, idx, act, exp);
    end
  endtask
  task automatic add_rst();
    vecs.push_back('{r: 1'b1, b: 1'b1, e: 1'b0});
  endtask
  task automatic add_seq(input string bits, input string exp);
    for (int i = 0; i < bits.len(); i++)
      vecs.push_back('{r: 1'b0, b: bits[i] == "1", e: exp[i] == "1"});
  endtask
  task automatic step_a(input string name, input int idx, input logic r, input logic b, input logic e);
    reset_a = r;
    if_a.inbits = b;
    @(posedge clk);
    #1;
    chk(name, idx, if_a.detect, e);
  endtask
  task automatic step_b(input string name, input int idx, input logic r, input logic b, input logic e);
    reset_b = r;
    if_b.inbits = b;
    @(posedge clk);
    #1;
    chk(name, idx, if_b.detect, e);
  endtask
  initial begin
    if_a.inbits = 1'b1;
    if_b.inbits = 1'b1;
    #1;
    chk("powerup_a", 0, if_a.detect, 1'b0);
    chk("powerup_b", 0, if_b.detect, 1'b0);
    add_rst();
    add_rst();
    add_seq("011", "000");
    add_rst();
    add_seq("1010110101110110100", "0000010000100010000");
    add_rst();
    add_seq("1011011", "0001000");
    add_rst();
    add_seq("101011", "000001");
    add_rst();
    add_seq("111011", "000001");
    foreach (vecs[i]) step_a("table", i, vecs[i].r, vecs[i].b, vecs[i].e);
    step_a("midrst", 0, 1'b1, 1'b0, 1'b0);
    step_a("midrst", 1, 1'b0, 1'b1, 1'b0);
    step_a("midrst", 2, 1'b0, 1'b0, 1'b0);
    step_a("midrst", 3, 1'b0, 1'b1, 1'b0);
    step_a("midrst", 4, 1'b1, 1'b1, 1'b0);
    step_a("midrst", 5, 1'b0, 1'b1, 1'b0);
    step_a("midrst", 6, 1'b0, 1'b0, 1'b0);
    step_a("midrst", 7, 1'b0, 1'b1, 1'b0);
    step_a("midrst", 8, 1'b0, 1'b1, 1'b1);
    step_a("midrst", 9, 1'b0, 1'b0, 1'b0);
    step_b("len1", 0, 1'b1, 1'b1, 1'b0);
    step_b("len1", 1, 1'b0, 1'b1, 1'b1);
    step_b("len1", 2, 1'b0, 1'b1, 1'b1);
    step_b("len1", 3, 1'b0, 1'b0, 1'b0);
    step_b("len1", 4, 1'b0, 1'b1, 1'b1);
    step_b("len1", 5, 1'b1, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
